// File: rtl/mips_pkg.sv
// Shared MIPS definitions: widths, opcode/funct encodings, ALU op codes and
// the control bundle produced by the decoder.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_RD   = 2'd1,
    DEST_RT   = 2'd2
  } dest_sel_e;

  // reads_rt is not an output control; it only feeds load-use detection.
  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      jump;
    logic      alu_src;
    logic      reads_rt;
    alu_op_e   alu_op;
    dest_sel_e dest_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'('0);

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure combinational opcode/funct to control-bundle decoder.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o
);

  // Unknown opcodes or funct codes leave every control at zero (NOP).
  always_comb begin
    ctrl_o = CTRL_NOP;
    unique case (opcode_i)
      OP_RTYPE: begin
        // rt is an operand for every R-type encoding, known funct or not.
        ctrl_o.reads_rt = 1'b1;
        unique case (funct_i)
          FN_ADD: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_ADD; ctrl_o.dest_sel = DEST_RD; end
          FN_SUB: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_SUB; ctrl_o.dest_sel = DEST_RD; end
          FN_AND: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_AND; ctrl_o.dest_sel = DEST_RD; end
          FN_OR:  begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_OR;  ctrl_o.dest_sel = DEST_RD; end
          FN_SLT: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_SLT; ctrl_o.dest_sel = DEST_RD; end
          default: ;
        endcase
      end
      OP_LW: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.dest_sel  = DEST_RT;
      end
      OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reads_rt  = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch   = 1'b1;
        ctrl_o.reads_rt = 1'b1;
        ctrl_o.alu_op   = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.dest_sel  = DEST_RT;
      end
      OP_J: begin
        ctrl_o.jump = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID stage decode, write-back bypass, load-use hazard detection and the
// ID/EX pipeline register feeding the ALU stage.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_instr,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall_out,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_alu_src,
  output logic [3:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_rs_val,
  output logic [DATA_W-1:0] ex_rt_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dest,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_jtarget
);

  ctrl_t             ctrl;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic              load_use;

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              branch_q, branch_d;
  logic              jump_q, jump_d;
  logic              alu_src_q, alu_src_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] rs_val_q, rs_val_d;
  logic [DATA_W-1:0] rt_val_q, rt_val_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [DATA_W-1:0] jtarget_q, jtarget_d;

  assign id_rs = id_instr[25:21];
  assign id_rt = id_instr[20:16];
  assign id_rd = id_instr[15:11];

  mips_ctrl_decode u_decode (
    .opcode_i (id_instr[31:26]),
    .funct_i  (id_instr[5:0]),
    .ctrl_o   (ctrl)
  );

  // Operand select: $zero wins, then a same-cycle write-back, then the regfile.
  always_comb begin
    rs_fwd = rs_data;
    rt_fwd = rt_data;
    if (id_rs == '0)
      rs_fwd = '0;
    else if (wb_we && (wb_addr != '0) && (wb_addr == id_rs))
      rs_fwd = wb_data;
    if (id_rt == '0)
      rt_fwd = '0;
    else if (wb_we && (wb_addr != '0) && (wb_addr == id_rt))
      rt_fwd = wb_data;
  end

  // Load in EX whose result is needed by the instruction now in ID.
  always_comb begin
    load_use = valid_q && mem_read_q && (dest_q != '0) && id_valid &&
               ((dest_q == id_rs) || (ctrl.reads_rt && (dest_q == id_rt)));
    stall_out = load_use && !flush;
  end

  // Next ID/EX contents: a fully zeroed bubble unless a live instruction advances.
  always_comb begin
    valid_d     = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    alu_src_d   = 1'b0;
    alu_op_d    = '0;
    rs_val_d    = '0;
    rt_val_d    = '0;
    imm_d       = '0;
    rs_d        = '0;
    rt_d        = '0;
    dest_d      = '0;
    pc4_d       = '0;
    jtarget_d   = '0;
    if (id_valid && !flush && !load_use) begin
      valid_d     = 1'b1;
      reg_write_d = ctrl.reg_write;
      mem_read_d  = ctrl.mem_read;
      mem_write_d = ctrl.mem_write;
      branch_d    = ctrl.branch;
      jump_d      = ctrl.jump;
      alu_src_d   = ctrl.alu_src;
      alu_op_d    = ctrl.alu_op;
      rs_val_d    = rs_fwd;
      rt_val_d    = rt_fwd;
      imm_d       = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
      rs_d        = id_rs;
      rt_d        = id_rt;
      unique case (ctrl.dest_sel)
        DEST_RD: dest_d = id_rd;
        DEST_RT: dest_d = id_rt;
        default: dest_d = '0;
      endcase
      pc4_d       = id_pc4;
      jtarget_d   = {id_pc4[DATA_W-1 -: 4], id_instr[25:0], 2'b00};
    end
  end

  // ID/EX pipeline register; reset clears the in-flight slot immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      dest_q      <= '0;
      pc4_q       <= '0;
      jtarget_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      branch_q    <= branch_d;
      jump_q      <= jump_d;
      alu_src_q   <= alu_src_d;
      alu_op_q    <= alu_op_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      dest_q      <= dest_d;
      pc4_q       <= pc4_d;
      jtarget_q   <= jtarget_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;
  assign ex_branch    = branch_q;
  assign ex_jump      = jump_q;
  assign ex_alu_src   = alu_src_q;
  assign ex_alu_op    = alu_op_q;
  assign ex_rs_val    = rs_val_q;
  assign ex_rt_val    = rt_val_q;
  assign ex_imm       = imm_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_dest      = dest_q;
  assign ex_pc4       = pc4_q;
  assign ex_jtarget   = jtarget_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode / ID-EX pipeline stage of the MIPS core; sits directly downstream of the register file.
- Takes the IF/ID instruction plus the two register-file read values, decodes control and sign-extends the immediate.
- Bypasses same-cycle write-back data and detects load-use hazards, stalling upstream and inserting a bubble.
- Registers everything into the ID/EX boundary consumed by the ALU stage.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  DATA_W  instruction word.
- id_pc4  in  DATA_W  PC+4 of that instruction.
- rs_data  in  DATA_W  register-file value for instr[25:21].
- rt_data  in  DATA_W  register-file value for instr[20:16].
- wb_we  in  1  write-back write enable, same cycle.
- wb_addr  in  REG_AW  write-back destination.
- wb_data  in  DATA_W  write-back value.
- flush  in  1  branch/jump resolved taken; kill instruction in ID.
- stall_out  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX slot holds a real instruction.
- ex_reg_write  out  1  instruction writes a register.
- ex_mem_read  out  1  load.
- ex_mem_write  out  1  store.
- ex_branch  out  1  beq.
- ex_jump  out  1  j.
- ex_alu_src  out  1  ALU operand B is the immediate.
- ex_alu_op  out  4  ALU function: 0 add, 1 sub, 2 and, 3 or, 4 slt.
- ex_rs_val  out  DATA_W  operand A.
- ex_rt_val  out  DATA_W  operand B / store data.
- ex_imm  out  DATA_W  sign-extended instr[15:0].
- ex_rs  out  REG_AW  rs field.
- ex_rt  out  REG_AW  rt field.
- ex_dest  out  REG_AW  destination: rd for R-type, rt for lw/addi, 0 otherwise.
- ex_pc4  out  DATA_W  PC+4.
- ex_jtarget  out  DATA_W  {id_pc4[31:28], instr[25:0], 2'b00}.

Behaviour:
- Reset: all outputs and ID/EX registers go to 0 immediately on rst rising; ex_valid=0, stall_out=0. Reset mid-operation discards the in-flight slot; no partial state survives.
- Decode (combinational, opcode/funct):
  - R-type 000000 with funct 100000/100010/100100/100101/101010 → add/sub/and/or/slt, reg_write=1, dest=rd.
  - lw 100011: mem_read, alu_src, add, dest=rt.
  - sw 101011: mem_write, alu_src, add, no reg_write.
  - beq 000100: branch, sub.
  - addi 001000: alu_src, add, dest=rt.
  - j 000010: jump.
  - Unknown opcode/funct: all controls 0, ex_valid still follows id_valid (NOP).
- Write-back bypass:
  - If wb_we=1, wb_addr!=0 and wb_addr==rs, then ex_rs_val takes wb_data instead of rs_data.
  - Same rule for rt. Register 0 always reads 0 regardless of inputs.
- Load-use hazard: stall_out=1 when ex_valid & ex_mem_read & ex_dest!=0 and ex_dest equals id rs, or equals id rt for instructions that read rt (R-type, sw, beq).
- During a stall, the ID/EX slot loads a bubble (ex_valid=0, all controls 0, data don't-care but driven 0). stall_out is combinational from current ID/EX contents and is 0 the following cycle.
- flush=1: ID/EX loads a bubble at the next edge and stall_out is forced 0. flush has priority over stall.
- Latency: one cycle, ID → ID/EX. Without stall or flush, every cycle captures decoded id_* when id_valid=1; when id_valid=0 it captures a bubble.
- ex_imm: sign extension of instr[15:0] into DATA_W; no zero-extend variants.

Decomposition:
- Shared package mips_pkg holds opcode constants, funct constants, ALU_ADD..ALU_SLT encodings, and DATA_W/REG_AW defaults.
- One sub-module, mips_ctrl_decode: pure combinational opcode/funct → control bundle, reusable by later stages.
- Hazard, bypass and pipeline registers stay in id_ex_stage.

Test Plan:
- Reset: assert rst mid-stream with ex_valid=1 → all outputs 0 at once; first valid add after release appears one cycle later.
- add $t2,$t0,$t1 (0x01095020) with rs_data=5, rt_data=7 → next cycle ex_alu_op=0, ex_dest=10, ex_rs_val=5, ex_rt_val=7, ex_reg_write=1.
- Bypass: same add with wb_we=1, wb_addr=8, wb_data=0x99, rs_data=5 → ex_rs_val=0x99. With wb_addr=0 → ex_rs_val=5.
- Load-use: lw $t0,0($s0) followed by add using $t0 → stall_out=1 for exactly one cycle, bubble in ID/EX, add captured the cycle after.
- Flush plus hazard in the same cycle → bubble captured, stall_out=0.
- addi with imm 0xFFFC → ex_imm=0xFFFFFFFC, alu_src=1. Unknown opcode 0x3F → all controls 0.
